mem_access_ctrl: RTL and testbench

Sequencer and arbiter for the shared `memory` unit of the simple RISC CPU. It accepts word read and write requests from two requesters: the instruction-fetch port (read-only) and the data port (read/write). It grants one request at a time and drives the memory's MAR/MDR control strobes (`MAin`, `MDbus`, `read`, `write`, `MDout`) in the fixed phase order the memory requires. It places address and write data on the shared tri-state `bus`, samples read data from it, and stretches the access while the memory asserts `Wait`.

---
 rtl/mem_access_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: arbitrates fetch/data word accesses to the shared memory unit and sequences
// the MAin/MDbus/read/write/MDout strobes. Define MEMCTRL_ROUNDROBIN_EN for round-robin arbitration.
module mem_access_ctrl #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    inout  wire  [W-1:0] bus,
    output logic         MAin,
    output logic         MDbus,
    output logic         read,
    output logic         write,
    output logic         MDout,
    input  logic         Wait,
    input  logic         req_f,
    input  logic [W-1:0] addr_f,
    output logic         gnt_f,
    output logic         done_f,
    input  logic         req_d,
    input  logic         we_d,
    input  logic [W-1:0] addr_d,
    input  logic [W-1:0] wdata_d,
    output logic         gnt_d,
    output logic         done_d,
    output logic [W-1:0] rdata,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4,
        S_RDATA = 3'd5
    } state_e;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_e;

    state_e       state_q, state_d;
    req_id_e      owner_q, owner_d;
    logic [W-1:0] acc_addr_q, acc_addr_d;
    logic [W-1:0] acc_wdata_q, acc_wdata_d;
    logic         acc_we_q, acc_we_d;
    logic [W-1:0] rdata_q, rdata_d;

    logic ma_in_q, ma_in_d;
    logic md_bus_q, md_bus_d;
    logic rd_stb_q, rd_stb_d;
    logic wr_stb_q, wr_stb_d;
    logic md_out_q, md_out_d;
    logic done_fetch_q, done_fetch_d;
    logic done_data_q, done_data_d;
    logic busy_q, busy_d;

    logic grant;
    logic pick_data;

    assign grant = (state_q == S_IDLE) && (req_f || req_d) && !rst;

`ifdef MEMCTRL_ROUNDROBIN_EN
    // Holds the requester that wins the next tie; starting at fetch makes fetch win the first tie.
    req_id_e rr_prio_q, rr_prio_d;

    always_comb begin
        pick_data = req_d;
        if (req_f && req_d) begin
            pick_data = (rr_prio_q == REQ_DATA);
        end
    end

    always_comb begin
        rr_prio_d = rr_prio_q;
        if (grant) begin
            rr_prio_d = pick_data ? REQ_FETCH : REQ_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_prio_q <= REQ_FETCH;
        end else begin
            rr_prio_q <= rr_prio_d;
        end
    end
`else
    assign pick_data = req_d;
`endif

    assign gnt_f = grant && !pick_data;
    assign gnt_d = grant && pick_data;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d      = state_q;
        owner_d      = owner_q;
        acc_addr_d   = acc_addr_q;
        acc_wdata_d  = acc_wdata_q;
        acc_we_d     = acc_we_q;
        rdata_d      = rdata_q;
        done_fetch_d = 1'b0;
        done_data_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (grant) begin
                    owner_d     = pick_data ? REQ_DATA : REQ_FETCH;
                    acc_addr_d  = pick_data ? addr_d : addr_f;
                    acc_we_d    = pick_data && we_d;
                    acc_wdata_d = wdata_d;
                    state_d     = S_ADDR;
                end
            end
            S_ADDR: begin
                state_d = acc_we_q ? S_WDATA : S_READ;
            end
            S_WDATA: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (!Wait) begin
                    state_d      = S_IDLE;
                    done_fetch_d = (owner_q == REQ_FETCH);
                    done_data_d  = (owner_q == REQ_DATA);
                end
            end
            S_READ: begin
                if (!Wait) begin
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                rdata_d      = bus;
                state_d      = S_IDLE;
                done_fetch_d = (owner_q == REQ_FETCH);
                done_data_d  = (owner_q == REQ_DATA);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes are decoded from the next state so the registered copy lines up with the state itself.
    always_comb begin
        ma_in_d  = (state_d == S_ADDR);
        md_bus_d = (state_d == S_WDATA);
        rd_stb_d = (state_d == S_READ);
        wr_stb_d = (state_d == S_WRITE);
        md_out_d = (state_d == S_RDATA);
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= REQ_FETCH;
            rdata_q      <= '0;
            ma_in_q      <= 1'b0;
            md_bus_q     <= 1'b0;
            rd_stb_q     <= 1'b0;
            wr_stb_q     <= 1'b0;
            md_out_q     <= 1'b0;
            done_fetch_q <= 1'b0;
            done_data_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rdata_q      <= rdata_d;
            ma_in_q      <= ma_in_d;
            md_bus_q     <= md_bus_d;
            rd_stb_q     <= rd_stb_d;
            wr_stb_q     <= wr_stb_d;
            md_out_q     <= md_out_d;
            done_fetch_q <= done_fetch_d;
            done_data_q  <= done_data_d;
            busy_q       <= busy_d;
        end
    end

    // NOTE: operand registers carry no reset; they are always loaded at grant before anything reads them.
    always_ff @(posedge clk) begin
        acc_addr_q  <= acc_addr_d;
        acc_wdata_q <= acc_wdata_d;
        acc_we_q    <= acc_we_d;
    end

    // Only ADDR and WDATA own the bus; every other state leaves it to the memory or floating.
    assign bus = (state_q == S_ADDR)  ? acc_addr_q  :
                 (state_q == S_WDATA) ? acc_wdata_q : {W{1'bz}};

    assign MAin   = ma_in_q;
    assign MDbus  = md_bus_q;
    assign read   = rd_stb_q;
    assign write  = wr_stb_q;
    assign MDout  = md_out_q;
    assign done_f = done_fetch_q;
    assign done_d = done_data_q;
    assign busy   = busy_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a small MAR/MDR memory model sharing the tri-state bus.
module tb_mem_access_ctrl;
    localparam int W = 32;
    // Value the bench's bus keeper drives whenever neither side should own the bus.
    localparam logic [W-1:0] KEEP = '0;

    logic         clk = 1'b0;
    logic         rst;
    wire  [W-1:0] bus;
    logic         MAin, MDbus, read, write, MDout;
    logic         Wait;
    logic         req_f, gnt_f, done_f;
    logic [W-1:0] addr_f;
    logic         req_d, we_d, gnt_d, done_d;
    logic [W-1:0] addr_d, wdata_d;
    logic [W-1:0] rdata;
    logic         busy;

    int total = 0;
    int bad   = 0;
    logic mon_en = 1'b0;

    logic [W-1:0] mem [16];
    logic [W-1:0] mar, mdr;
    logic [9:0]   ctl_obs;

    always #5 clk = ~clk;

    mem_access_ctrl #(.W(W)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .MAin(MAin), .MDbus(MDbus), .read(read), .write(write), .MDout(MDout),
        .Wait(Wait),
        .req_f(req_f), .addr_f(addr_f), .gnt_f(gnt_f), .done_f(done_f),
        .req_d(req_d), .we_d(we_d), .addr_d(addr_d), .wdata_d(wdata_d),
        .gnt_d(gnt_d), .done_d(done_d),
        .rdata(rdata), .busy(busy)
    );

    assign ctl_obs = {gnt_f, gnt_d, done_f, done_d, busy, MAin, MDbus, read, write, MDout};

    // Memory model: MAR/MDR loads, read into MDR, write from MDR, MDR onto the bus under MDout.
    assign bus = MDout ? mdr : ((MAin || MDbus) ? {W{1'bz}} : KEEP);

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = W'(32'h100 + i);
        mem[2] = 32'd9;
        mar = '0;
        mdr = '0;
    end

    always @(posedge clk) begin
        if (MAin) mar <= bus;
        if (MDbus) mdr <= bus;
        if (read) mdr <= mem[mar[3:0]];
        if (write && !Wait) mem[mar[3:0]] <= mdr;
    end

    // Continuous bus-ownership and strobe-exclusivity monitor.
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if (!$onehot0({MAin, MDbus, read, write, MDout})) begin
                bad++;
                $display("FAIL strobe_excl t=%0t strobes=%b want at most one high", $time,
                         {MAin, MDbus, read, write, MDout});
            end
            if (MDout) begin
                total++;
                if (bus !== mdr) begin
                    bad++;
                    $display("FAIL bus_own t=%0t bus=%h want memory value %h", $time, bus, mdr);
                end
            end
        end
    end

    task automatic test_reset;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (ctl_obs !== 10'b0) begin
            bad++;
            $display("FAIL reset_ctl got=%b want=%b", ctl_obs, 10'b0);
        end
        total++;
        if (rdata !== '0) begin
            bad++;
            $display("FAIL reset_rdata got=%h want=%h", rdata, {W{1'b0}});
        end
        total++;
        if (bus !== KEEP) begin
            bad++;
            $display("FAIL reset_bus got=%h want=%h", bus, KEEP);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (ctl_obs !== 10'b0) begin
            bad++;
            $display("FAIL reset_release_ctl got=%b want=%b", ctl_obs, 10'b0);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_write;
        logic [9:0]   ex_c [5];
        logic [W-1:0] ex_b [5];
        ex_c = '{10'b0100000000, 10'b0000110000, 10'b0000101000, 10'b0000100010, 10'b0001000000};
        ex_b = '{KEEP, 32'd1, 32'd8, KEEP, KEEP};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) begin
                req_d = 1'b1; we_d = 1'b1; addr_d = 32'd1; wdata_d = 32'd8;
            end else if (c == 1) begin
                req_d = 1'b0; we_d = 1'b0; addr_d = '1; wdata_d = '1;
            end
            #1;
            total++;
            if (ctl_obs !== ex_c[c]) begin
                bad++;
                $display("FAIL write_ctl cyc%0d got=%b want=%b", c, ctl_obs, ex_c[c]);
            end
            total++;
            if (bus !== ex_b[c]) begin
                bad++;
                $display("FAIL write_bus cyc%0d got=%h want=%h", c, bus, ex_b[c]);
            end
        end
    endtask

    task automatic test_read(input string name, input bit fetch, input logic [W-1:0] addr,
                             input logic [W-1:0] data, input logic [W-1:0] prev, input int nw);
        logic [9:0]   ex;
        logic [W-1:0] eb;
        for (int c = 0; c < 5 + nw; c++) begin
            @(negedge clk);
            Wait = (c >= 2) && (c < 2 + nw);
            if (c == 0) begin
                if (fetch) begin
                    req_f = 1'b1; addr_f = addr;
                end else begin
                    req_d = 1'b1; we_d = 1'b0; addr_d = addr; wdata_d = '1;
                end
            end else if (c == 1) begin
                req_f = 1'b0; req_d = 1'b0; addr_f = '1; addr_d = '1;
            end
            if (c == 0) begin
                ex = fetch ? 10'b1000000000 : 10'b0100000000; eb = KEEP;
            end else if (c == 1) begin
                ex = 10'b0000110000; eb = addr;
            end else if (c <= 2 + nw) begin
                ex = 10'b0000100100; eb = KEEP;
            end else if (c == 3 + nw) begin
                ex = 10'b0000100001; eb = data;
            end else begin
                ex = fetch ? 10'b0010000000 : 10'b0001000000; eb = KEEP;
            end
            #1;
            total++;
            if (ctl_obs !== ex) begin
                bad++;
                $display("FAIL %s_ctl cyc%0d got=%b want=%b", name, c, ctl_obs, ex);
            end
            total++;
            if (bus !== eb) begin
                bad++;
                $display("FAIL %s_bus cyc%0d got=%h want=%h", name, c, bus, eb);
            end
            if (c == 3 + nw) begin
                total++;
                if (rdata !== prev) begin
                    bad++;
                    $display("FAIL %s_rdata_hold got=%h want=%h", name, rdata, prev);
                end
            end
            if (c == 4 + nw) begin
                total++;
                if (rdata !== data) begin
                    bad++;
                    $display("FAIL %s_rdata got=%h want=%h", name, rdata, data);
                end
            end
        end
        Wait = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [9:0]   ex_c [9];
        logic [W-1:0] ex_b [9];
        ex_c = '{10'b0100000000, 10'b0000110000, 10'b0000101000, 10'b0000100010, 10'b0101000000,
                 10'b0000110000, 10'b0000101000, 10'b0000100010, 10'b0001000000};
        ex_b = '{KEEP, 32'd3, 32'd5, KEEP, KEEP, 32'd4, 32'd6, KEEP, KEEP};
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c == 0) begin
                req_d = 1'b1; we_d = 1'b1; addr_d = 32'd3; wdata_d = 32'd5;
            end else if (c == 1) begin
                addr_d = 32'd4; wdata_d = 32'd6;
            end else if (c == 5) begin
                req_d = 1'b0; we_d = 1'b0;
            end
            #1;
            total++;
            if (ctl_obs !== ex_c[c]) begin
                bad++;
                $display("FAIL b2b_ctl cyc%0d got=%b want=%b", c, ctl_obs, ex_c[c]);
            end
            total++;
            if (bus !== ex_b[c]) begin
                bad++;
                $display("FAIL b2b_bus cyc%0d got=%h want=%h", c, bus, ex_b[c]);
            end
        end
    endtask

    task automatic test_tie;
        logic [9:0]   ex_c [9];
        logic [W-1:0] ex_b [9];
        logic [W-1:0] r4, r8;
`ifdef MEMCTRL_ROUNDROBIN_EN
        ex_c = '{10'b1000000000, 10'b0000110000, 10'b0000100100, 10'b0000100001, 10'b0110000000,
                 10'b0000110000, 10'b0000100100, 10'b0000100001, 10'b0001000000};
        ex_b = '{KEEP, 32'd5, KEEP, 32'h105, KEEP, 32'd2, KEEP, 32'd9, KEEP};
        r4 = 32'h105; r8 = 32'd9;
`else
        ex_c = '{10'b0100000000, 10'b0000110000, 10'b0000100100, 10'b0000100001, 10'b1001000000,
                 10'b0000110000, 10'b0000100100, 10'b0000100001, 10'b0010000000};
        ex_b = '{KEEP, 32'd2, KEEP, 32'd9, KEEP, 32'd5, KEEP, 32'h105, KEEP};
        r4 = 32'd9; r8 = 32'h105;
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c == 0) begin
                req_f = 1'b1; addr_f = 32'd5;
                req_d = 1'b1; we_d = 1'b0; addr_d = 32'd2;
            end else if (c == 1) begin
`ifdef MEMCTRL_ROUNDROBIN_EN
                req_f = 1'b0;
`else
                req_d = 1'b0;
`endif
            end else if (c == 5) begin
                req_f = 1'b0; req_d = 1'b0;
            end
            #1;
            total++;
            if (ctl_obs !== ex_c[c]) begin
                bad++;
                $display("FAIL tie_ctl cyc%0d got=%b want=%b", c, ctl_obs, ex_c[c]);
            end
            total++;
            if (bus !== ex_b[c]) begin
                bad++;
                $display("FAIL tie_bus cyc%0d got=%h want=%h", c, bus, ex_b[c]);
            end
            if (c == 4 || c == 8) begin
                total++;
                if (rdata !== ((c == 4) ? r4 : r8)) begin
                    bad++;
                    $display("FAIL tie_rdata cyc%0d got=%h want=%h", c, rdata, (c == 4) ? r4 : r8);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [9:0]   ex_c [6];
        logic [W-1:0] ex_b [6];
        ex_c = '{10'b0100000000, 10'b0000110000, 10'b0000101000, 10'b0000100010, 10'b0, 10'b0};
        ex_b = '{KEEP, 32'd6, 32'h77, KEEP, KEEP, KEEP};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) begin
                req_d = 1'b1; we_d = 1'b1; addr_d = 32'd6; wdata_d = 32'h77;
            end else if (c == 1) begin
                req_d = 1'b0; we_d = 1'b0;
            end else if (c == 3) begin
                rst = 1'b1;
            end else if (c == 4) begin
                rst = 1'b0;
            end
            #1;
            total++;
            if (ctl_obs !== ex_c[c]) begin
                bad++;
                $display("FAIL rstmid_ctl cyc%0d got=%b want=%b", c, ctl_obs, ex_c[c]);
            end
            total++;
            if (bus !== ex_b[c]) begin
                bad++;
                $display("FAIL rstmid_bus cyc%0d got=%h want=%h", c, bus, ex_b[c]);
            end
            if (c == 4) begin
                total++;
                if (rdata !== '0) begin
                    bad++;
                    $display("FAIL rstmid_rdata got=%h want=%h", rdata, {W{1'b0}});
                end
            end
        end
        test_read("after_rst", 1'b1, 32'd1, 32'd8, 32'd0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; Wait = 1'b0;
        req_f = 1'b0; addr_f = '0;
        req_d = 1'b0; we_d = 1'b0; addr_d = '0; wdata_d = '0;
        test_reset();
        test_write();
        test_read("read1", 1'b1, 32'd1, 32'd8, 32'd0, 0);
        test_read("read2", 1'b1, 32'd2, 32'd9, 32'd8, 0);
        test_read("wait", 1'b0, 32'd1, 32'd8, 32'd9, 3);
        test_back_to_back();
        test_tie();
        test_reset_mid();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
